// File: rtl/bsram_access_aligner_pkg.sv
// Shared definitions for the BSRAM access aligner.
// Provides the access-size and FSM-state encodings, the captured load-control
// payload, and the misalignment rule used on request acceptance.
package bsram_access_aligner_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned OFF_W  = 2;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_ISSUE   = 3'd1,
    ST_RD_CAPTURE = 3'd2,
    ST_WR_ISSUE   = 3'd3,
    ST_RESP       = 3'd4
  } state_e;

  // Load attributes captured at accept, consumed when readData returns.
  typedef struct packed {
    size_e            size;
    logic             sext;
    logic [OFF_W-1:0] off;
  } ld_ctrl_t;

  // An access is misaligned when its byte offset is not a multiple of its size.
  function automatic logic is_misaligned(input size_e size, input logic [OFF_W-1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != '0);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bsram_access_aligner_if.sv
// Core-side load/store request/response bus of the BSRAM access aligner.
//   master : the core (drives requests, consumes responses)
//   slave  : the aligner (accepts requests, produces responses)
interface bsram_access_aligner_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/bsram_access_aligner_mem_lane_formatter.sv
// Combinational byte-lane formatter.
//   st_size/st_off/st_wdata -> st_be_c, st_data_c : store lane enables and
//                                                    lane-replicated store data
//   ld_ctrl/ld_rdata        -> ld_data_c           : lane extract plus sign/zero
//                                                    extension of load data
module bsram_access_aligner_mem_lane_formatter
  import bsram_access_aligner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  size_e                 st_size,
  input  logic [OFF_W-1:0]      st_off,
  input  logic [DATA_WIDTH-1:0] st_wdata,
  output logic [LANES-1:0]      st_be_c,
  output logic [DATA_WIDTH-1:0] st_data_c,
  input  ld_ctrl_t              ld_ctrl,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [DATA_WIDTH-1:0] ld_data_c
);

  logic [DATA_WIDTH-1:0] lane;

  // Store: replicate the right-justified value into every lane it could occupy.
  always_comb begin
    st_be_c   = '0;
    st_data_c = st_wdata;
    case (st_size)
      SIZE_BYTE: begin
        st_be_c   = LANES'(4'b0001 << st_off);
        st_data_c = {LANES{st_wdata[LANE_W-1:0]}};
      end
      SIZE_HALF: begin
        st_be_c   = LANES'(4'b0011 << st_off);
        st_data_c = {2{st_wdata[2*LANE_W-1:0]}};
      end
      SIZE_WORD: begin
        st_be_c   = '1;
        st_data_c = st_wdata;
      end
      default: begin
        st_be_c   = '0;
        st_data_c = st_wdata;
      end
    endcase
  end

  // Load: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    lane      = ld_rdata >> {ld_ctrl.off, 3'b000};
    ld_data_c = '0;
    case (ld_ctrl.size)
      SIZE_BYTE: ld_data_c = {{(DATA_WIDTH-8){ld_ctrl.sext & lane[7]}}, lane[7:0]};
      SIZE_HALF: ld_data_c = {{(DATA_WIDTH-16){ld_ctrl.sext & lane[15]}}, lane[15:0]};
      SIZE_WORD: ld_data_c = lane;
      default:   ld_data_c = '0;
    endcase
  end

endmodule

// File: rtl/bsram_access_aligner.sv
// Front-end between a core load/store port and a byte-enabled flat BSRAM.
// Ports:
//   clock, reset    : clock and asynchronous active-low reset
//   bus (slave)     : core request/response handshake bus
//   readEnable/readAddress/readData          : BSRAM read port (1-cycle data)
//   writeEnable/writeByteEnable/writeAddress/writeData : BSRAM write port
// One request is outstanding at a time. Loads respond 2 cycles after accept,
// stores and misaligned requests 1 cycle after accept.
module bsram_access_aligner
  import bsram_access_aligner_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  bsram_access_aligner_if.slave bus,
  output logic                  readEnable,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  writeEnable,
  output logic [LANES-1:0]      writeByteEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData
);

  state_e                state_q, state_d;
  ld_ctrl_t              ld_q, ld_d;
  logic                  err_q, err_d;
  logic                  rd_en_d, wr_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_d, wr_addr_d;
  logic [LANES-1:0]      wr_be_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic [ADDR_WIDTH-1:0] word;
  logic [OFF_W-1:0]      off;
  size_e                 req_size;
  logic                  misaligned;
  logic                  accept;
  logic [LANES-1:0]      st_be;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] ld_data;

  assign word       = bus.req_addr[ADDR_WIDTH+1:2];
  assign off        = bus.req_addr[1:0];
  assign req_size   = size_e'(bus.req_size);
  assign misaligned = is_misaligned(req_size, off);

  // Ready in IDLE, or in RESP when the response retires on the same edge.
  // Gated by reset so the port reads 0 while reset is held.
  assign bus.req_ready = reset & ((state_q == ST_IDLE) |
                                  ((state_q == ST_RESP) & bus.rsp_ready));
  assign accept        = bus.req_valid & bus.req_ready;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

  bsram_access_aligner_mem_lane_formatter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_lane_formatter (
    .st_size   (req_size),
    .st_off    (off),
    .st_wdata  (bus.req_wdata),
    .st_be_c   (st_be),
    .st_data_c (st_data),
    .ld_ctrl   (ld_q),
    .ld_rdata  (readData),
    .ld_data_c (ld_data)
  );

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      ld_q            <= '0;
      err_q           <= 1'b0;
      readEnable      <= 1'b0;
      readAddress     <= '0;
      writeEnable     <= 1'b0;
      writeByteEnable <= '0;
      writeAddress    <= '0;
      writeData       <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      ld_q            <= ld_d;
      err_q           <= err_d;
      readEnable      <= rd_en_d;
      readAddress     <= rd_addr_d;
      writeEnable     <= wr_en_d;
      writeByteEnable <= wr_be_d;
      writeAddress    <= wr_addr_d;
      writeData       <= wr_data_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_error_q     <= rsp_error_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ld_d        = ld_q;
    err_d       = err_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = readAddress;
    wr_en_d     = 1'b0;
    wr_be_d     = writeByteEnable;
    wr_addr_d   = writeAddress;
    wr_data_d   = writeData;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      ST_IDLE:     state_d = ST_IDLE;
      ST_RD_ISSUE: state_d = ST_RD_CAPTURE;
      ST_RD_CAPTURE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
        rsp_error_d = 1'b0;
      end
      // Shared by stores and rejected requests; err_q tells them apart.
      ST_WR_ISSUE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_error_d = err_q;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Accept is only possible from IDLE or a retiring RESP, so it overrides.
    if (accept) begin
      ld_d = '{size: req_size, sext: bus.req_signed, off: off};
      if (misaligned) begin
        // No strobe; passes through WR_ISSUE so the error lands one cycle later.
        state_d = ST_WR_ISSUE;
        err_d   = 1'b1;
      end else if (bus.req_write) begin
        state_d   = ST_WR_ISSUE;
        err_d     = 1'b0;
        wr_en_d   = 1'b1;
        wr_addr_d = word;
        wr_be_d   = st_be;
        wr_data_d = st_data;
      end else begin
        state_d   = ST_RD_ISSUE;
        err_d     = 1'b0;
        rd_en_d   = 1'b1;
        rd_addr_d = word;
      end
    end
  end

endmodule

// File: doc/bsram_access_aligner.md
Name: bsram_access_aligner

Overview:
- Front-end between the core's load/store port and the byte-enable flat BSRAM.
- Converts byte-addressed byte/half/word requests into word-addressed BSRAM reads and byte-enabled writes.
- Extracts and sign- or zero-extends load data, and flags misaligned accesses.
- Handles one outstanding request at a time, with valid/ready handshakes on both request and response sides.

Parameters:
- DATA_WIDTH, 32, BSRAM word width. Only 32 is supported; 4 byte lanes.
- ADDR_WIDTH, 8, BSRAM word-address width. The byte address is ADDR_WIDTH+2 bits.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted on a clock edge where req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  input  1  sign-extend load result.
- req_addr  input  ADDR_WIDTH+2  byte address.
- req_wdata  input  32  store value, right-justified.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_error  output  1  misaligned or illegal size.
- readEnable  output  1  BSRAM read strobe.
- readAddress  output  ADDR_WIDTH  BSRAM read word address.
- readData  input  32  BSRAM data, valid the cycle after the address is sampled.
- writeEnable  output  1  BSRAM write strobe.
- writeByteEnable  output  4  BSRAM lane enables.
- writeAddress  output  ADDR_WIDTH  BSRAM write word address.
- writeData  output  32  lane-replicated store data.

Behaviour:
- Reset (async, reset==0):
  - State returns to IDLE.
  - All outputs go to 0: req_ready, rsp_valid, rsp_rdata, rsp_error, readEnable, readAddress, writeEnable, writeByteEnable, writeAddress, writeData.
- Reset mid-operation: the pending request is dropped and writeEnable falls immediately. No response is produced after reset releases.
- Address split: word = req_addr[ADDR_WIDTH+1:2], off = req_addr[1:0].
- Misaligned condition: size 11; half with off[0]=1; word with off!=0.
- FSM states: IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, RESP.
- IDLE:
  - req_ready=1.
  - Accept of an aligned load → RD_ISSUE. readEnable=1 and readAddress=word are registered at the accept edge.
  - Accept of an aligned store → WR_ISSUE. writeEnable=1, writeAddress, writeByteEnable and writeData are registered.
  - Accept of a misaligned request → RESP with rsp_error=1 and rsp_rdata=0. No BSRAM strobe is issued.
- RD_ISSUE: lasts one cycle. readEnable drops at exit. Next state RD_CAPTURE.
- RD_CAPTURE: at the exit edge, the extended readData is latched into rsp_rdata. Next state RESP.
- WR_ISSUE: lasts one cycle. writeEnable drops at exit. Next state RESP, with rsp_rdata=0.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_error are held stable until rsp_ready.
  - On rsp_ready → IDLE.
  - req_ready = rsp_ready in this state (back-to-back accept). A request accepted here is processed exactly as if accepted from IDLE.
- Latency from the accept edge N: load rsp_valid at N+2, store at N+1, error at N+1.
- Addresses and writeData hold their last values when the strobes are low.
- Store formatting:
  - Byte: BE = 0001<<off, data = {4{wdata[7:0]}}.
  - Half: BE = 0011<<off, data = {2{wdata[15:0]}}.
  - Word: BE = 1111, data = wdata.
- Load formatting: lane = readData >> (8*off). The result is extended to 32 bits from 8 or 16 bits; sign-extend if req_signed, else zero-extend. Size, signed and off are captured at accept.

Decomposition:
- Shared package holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILLEGAL encodings.
  - FSM state encodings.
  - The misalignment function.
- One combinational sub-module, mem_lane_formatter, computes store BE/data and load extract/extend. The FSM stays in the top.

Test Plan:
- Word load: preload sram[2]=AAAA8888, load word at 0x08 → readEnable pulse with readAddress=2, then rsp_valid 2 cycles after accept with rsp_rdata=AAAA8888, rsp_error=0.
- Sub-word loads from the same word:
  - Half signed at 0x08 → FFFF8888.
  - Half unsigned at 0x08 → 00008888.
  - Byte signed at 0x0B → FFFFFFAA.
  - Byte unsigned at 0x0A → 000000AA.
- Stores:
  - Half store 0x0064 at 0x08 → single writeEnable cycle with writeAddress=2, writeByteEnable=0011, writeData=00640064. A subsequent word load returns AAAA0064.
  - Byte store 0x5A at 0x11 on sram[4]=11110000 → BE=0010, data=5A5A5A5A. Word load returns 11115A00.
- Misaligned: word at 0x0A, half at 0x09, size 11 → rsp_error=1 and rsp_rdata=0 at N+1; readEnable and writeEnable never assert.
- Back-pressure and reset:
  - Hold rsp_ready=0 for 5 cycles after a load → rsp_valid and rsp_rdata stable, req_ready=0.
  - Release with req_valid high → back-to-back accept on the same edge.
  - Assert reset during RD_CAPTURE → all outputs 0 asynchronously, and no stale response after release.
